// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: result-source select,
// load/store width (funct3) and the bus-side FSM state.
package mem_stage_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] MW_B  = 3'b000;
    localparam logic [2:0] MW_H  = 3'b001;
    localparam logic [2:0] MW_W  = 3'b010;
    localparam logic [2:0] MW_BU = 3'b100;
    localparam logic [2:0] MW_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic width_legal(input logic [2:0] w);
        case (w)
            MW_B, MW_H, MW_W, MW_BU, MW_HU: width_legal = 1'b1;
            default:                        width_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
// Handshake: a transfer completes on any clock edge where dmem_req and
// dmem_ready are both 1; while dmem_req=1 and dmem_ready=0 the master keeps
// dmem_we/addr/be/wdata stable; dmem_rdata is only meaningful on the
// completing edge of a read.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Shifts the addressed byte/halfword of a read word down to bit 0 and
// sign- or zero-extends it according to the load width.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  width_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (width_i)
            MW_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            MW_BU:   data_o = {24'h0, shifted[7:0]};
            MW_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            MW_HU:   data_o = {16'h0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-bus transfers, stalls on wait
// states, aligns load data and holds the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                stall_in,
    input  logic                rd_write_enable,
    input  logic [4:0]          rd_write_addr,
    input  logic [1:0]          res_src,
    input  logic                mem_write_enable,
    input  logic [2:0]          mem_width,
    input  logic [31:0]         exec_result,
    input  logic [31:0]         mem_write_data,
    input  logic [31:0]         next_pc,
    mem_stage_if.master         dmem,
    output logic                mem_stall,
    output logic                misaligned,
    output logic [31:0]         mem_forward,
    output logic                rd_write_enable_out,
    output logic [4:0]          rd_write_addr_out,
    output logic [1:0]          res_src_out,
    output logic [31:0]         alu_result_out,
    output logic [31:0]         load_data_out,
    output logic [31:0]         next_pc_out,
    output mem_state_t          fsm_state
);

    mem_state_t state_q, state_d;

    logic              is_load, is_store, want, aligned, access;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [ADDR_W-1:0] addr_c;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        width_q;
    logic [1:0]        off_q;
    logic              discard_q;

    logic [1:0]        align_off;
    logic [2:0]        align_width;
    logic [31:0]       load_data_c;
    logic              launch_wait, drop_result;

    logic              rd_we_q;
    logic [4:0]        rd_addr_q;
    logic [1:0]        res_src_q;
    logic [31:0]       alu_q, load_q, pc_q;

    assign is_load  = (res_src == RES_MEM);
    assign is_store = mem_write_enable;
    assign want     = reset && (is_load || is_store);
    assign addr_c   = {exec_result[ADDR_W-1:2], 2'b00};

    always_comb begin
        aligned = 1'b1;
        case (mem_width[1:0])
            2'b01:   aligned = ~exec_result[0];
            2'b10:   aligned = (exec_result[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign access = want && aligned && width_legal(mem_width);

    // Loads always fetch the full word; only stores narrow the byte enables.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = mem_write_data;
        if (is_store) begin
            case (mem_width[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << exec_result[1:0];
                    wdata_c = {4{mem_write_data[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << {exec_result[1], 1'b0};
                    wdata_c = {2{mem_write_data[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = mem_write_data;
                end
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access && !dmem.dmem_ready) state_d = ST_WAIT;
            ST_WAIT: if (dmem.dmem_ready)            state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        dmem.dmem_req   = 1'b0;
        dmem.dmem_we    = 1'b0;
        dmem.dmem_addr  = '0;
        dmem.dmem_be    = 4'b0000;
        dmem.dmem_wdata = 32'h0;
        misaligned      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dmem.dmem_req   = access;
                dmem.dmem_we    = access && is_store;
                dmem.dmem_addr  = access ? addr_c : '0;
                dmem.dmem_be    = access ? be_c : 4'b0000;
                dmem.dmem_wdata = access ? wdata_c : 32'h0;
                misaligned      = want && !access;
            end
            ST_WAIT: begin
                dmem.dmem_req   = reset;
                dmem.dmem_we    = reset && we_q;
                dmem.dmem_addr  = addr_q;
                dmem.dmem_be    = reset ? be_q : 4'b0000;
                dmem.dmem_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    assign mem_stall   = dmem.dmem_req && !dmem.dmem_ready;
    assign mem_forward = reset ? exec_result : 32'h0;
    assign fsm_state   = state_q;

    assign launch_wait = (state_q == ST_IDLE) && access && !dmem.dmem_ready;
    // A flush that lands on an outstanding transfer must not let its result reach writeback.
    assign drop_result = (state_q == ST_WAIT) && discard_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            width_q   <= 3'b000;
            off_q     <= 2'b00;
            discard_q <= 1'b0;
        end else if (launch_wait) begin
            addr_q    <= addr_c;
            we_q      <= is_store;
            be_q      <= be_c;
            wdata_q   <= wdata_c;
            width_q   <= mem_width;
            off_q     <= exec_result[1:0];
            discard_q <= flush;
        end else if (state_q == ST_WAIT) begin
            discard_q <= dmem.dmem_ready ? 1'b0 : (discard_q || flush);
        end
    end

    assign align_off   = (state_q == ST_WAIT) ? off_q   : exec_result[1:0];
    assign align_width = (state_q == ST_WAIT) ? width_q : mem_width;

    mem_stage_load_align u_load_align (
        .rdata_i  (dmem.dmem_rdata),
        .offset_i (align_off),
        .width_i  (align_width),
        .data_o   (load_data_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            res_src_q <= 2'b00;
            alu_q     <= 32'h0;
            load_q    <= 32'h0;
            pc_q      <= 32'h0;
        end else if (flush || mem_stall || drop_result) begin
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            res_src_q <= 2'b00;
            alu_q     <= 32'h0;
            load_q    <= 32'h0;
            pc_q      <= 32'h0;
        end else if (!stall_in) begin
            rd_we_q   <= rd_write_enable && !misaligned;
            rd_addr_q <= rd_write_addr;
            res_src_q <= res_src;
            alu_q     <= exec_result;
            load_q    <= load_data_c;
            pc_q      <= next_pc;
        end
    end

    assign rd_write_enable_out = rd_we_q;
    assign rd_write_addr_out   = rd_addr_q;
    assign res_src_out         = res_src_q;
    assign alu_result_out      = alu_q;
    assign load_data_out       = load_q;
    assign next_pc_out         = pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores, loads with extension, wait states,
// misalignment, flush and reset during an outstanding transfer.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        stall_in;
    logic        rd_write_enable;
    logic [4:0]  rd_write_addr;
    logic [1:0]  res_src;
    logic        mem_write_enable;
    logic [2:0]  mem_width;
    logic [31:0] exec_result;
    logic [31:0] mem_write_data;
    logic [31:0] next_pc;
    logic        mem_stall;
    logic        misaligned;
    logic [31:0] mem_forward;
    logic        rd_write_enable_out;
    logic [4:0]  rd_write_addr_out;
    logic [1:0]  res_src_out;
    logic [31:0] alu_result_out;
    logic [31:0] load_data_out;
    logic [31:0] next_pc_out;
    mem_state_t  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if #(.ADDR_W(32)) bus ();

    mem_stage #(.ADDR_W(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .stall_in            (stall_in),
        .rd_write_enable     (rd_write_enable),
        .rd_write_addr       (rd_write_addr),
        .res_src             (res_src),
        .mem_write_enable    (mem_write_enable),
        .mem_width           (mem_width),
        .exec_result         (exec_result),
        .mem_write_data      (mem_write_data),
        .next_pc             (next_pc),
        .dmem                (bus),
        .mem_stall           (mem_stall),
        .misaligned          (misaligned),
        .mem_forward         (mem_forward),
        .rd_write_enable_out (rd_write_enable_out),
        .rd_write_addr_out   (rd_write_addr_out),
        .res_src_out         (res_src_out),
        .alu_result_out      (alu_result_out),
        .load_data_out       (load_data_out),
        .next_pc_out         (next_pc_out),
        .fsm_state           (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] src, input logic we, input logic [2:0] width,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic rd_we, input logic [4:0] rd);
        res_src          = src;
        mem_write_enable = we;
        mem_width        = width;
        exec_result      = addr;
        mem_write_data   = wdata;
        rd_write_enable  = rd_we;
        rd_write_addr    = rd;
        next_pc          = addr + 32'd4;
    endtask

    task automatic bus_resp(input logic ready, input logic [31:0] rdata);
        bus.dmem_ready = ready;
        bus.dmem_rdata = rdata;
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        stall_in = 1'b0;
        drive_op(RES_MEM, 1'b0, MW_W, 32'h100, 32'h0, 1'b1, 5'd1);
        bus_resp(1'b1, 32'h0);
        step();
        check("rst_req",   32'(bus.dmem_req), 32'h0);
        check("rst_be",    32'(bus.dmem_be), 32'h0);
        check("rst_rdwe",  32'(rd_write_enable_out), 32'h0);
        check("rst_fwd",   mem_forward, 32'h0);
        check("rst_ld",    load_data_out, 32'h0);
        step();
        reset = 1'b1;

        // SW 0x100, zero wait
        drive_op(RES_ALU, 1'b1, MW_W, 32'h100, 32'hDEADBEEF, 1'b0, 5'd0);
        bus_resp(1'b1, 32'h0);
        #1;
        check("sw_req",   32'(bus.dmem_req), 32'h1);
        check("sw_we",    32'(bus.dmem_we), 32'h1);
        check("sw_addr",  bus.dmem_addr, 32'h100);
        check("sw_be",    32'(bus.dmem_be), 32'hF);
        check("sw_wdata", bus.dmem_wdata, 32'hDEADBEEF);
        check("sw_stall", 32'(mem_stall), 32'h0);
        step();
        check("sw_rdwe",  32'(rd_write_enable_out), 32'h0);
        check("sw_alu",   alu_result_out, 32'h100);

        // LB / LBU at 0x203
        drive_op(RES_MEM, 1'b0, MW_B, 32'h203, 32'h0, 1'b1, 5'd5);
        bus_resp(1'b1, 32'h80FF7F01);
        #1;
        check("lb_addr",  bus.dmem_addr, 32'h200);
        check("lb_be",    32'(bus.dmem_be), 32'hF);
        check("lb_we",    32'(bus.dmem_we), 32'h0);
        step();
        check("lb_data",  load_data_out, 32'hFFFFFF80);
        check("lb_rdwe",  32'(rd_write_enable_out), 32'h1);
        check("lb_rd",    32'(rd_write_addr_out), 32'd5);
        check("lb_src",   32'(res_src_out), 32'(RES_MEM));
        drive_op(RES_MEM, 1'b0, MW_BU, 32'h203, 32'h0, 1'b1, 5'd6);
        step();
        check("lbu_data", load_data_out, 32'h00000080);

        // LW misaligned, then illegal width
        drive_op(RES_MEM, 1'b0, MW_W, 32'h102, 32'h0, 1'b1, 5'd8);
        #1;
        check("mis_pulse", 32'(misaligned), 32'h1);
        check("mis_req",   32'(bus.dmem_req), 32'h0);
        step();
        check("mis_rdwe",  32'(rd_write_enable_out), 32'h0);
        drive_op(RES_ALU, 1'b0, MW_W, 32'h104, 32'h0, 1'b1, 5'd8);
        #1;
        check("mis_clear", 32'(misaligned), 32'h0);
        step();
        check("alu_rdwe",  32'(rd_write_enable_out), 32'h1);
        drive_op(RES_MEM, 1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 5'd8);
        #1;
        check("ill_pulse", 32'(misaligned), 32'h1);
        check("ill_req",   32'(bus.dmem_req), 32'h0);
        step();
        check("ill_rdwe",  32'(rd_write_enable_out), 32'h0);

        // LH 0x202 with three wait states; the bus must stay put even if the input moves
        drive_op(RES_MEM, 1'b0, MW_H, 32'h202, 32'h0, 1'b1, 5'd7);
        bus_resp(1'b0, 32'h0);
        #1;
        check("lh_stall0", 32'(mem_stall), 32'h1);
        check("lh_addr0",  bus.dmem_addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lh_bubble", 32'(rd_write_enable_out), 32'h0);
            check("lh_state",  32'(fsm_state), 32'(ST_WAIT));
            if (i < 2) begin
                exec_result = 32'hFFFF_FFF0;
                #1;
                check("lh_stall", 32'(mem_stall), 32'h1);
                check("lh_hold",  bus.dmem_addr, 32'h200);
                check("lh_beh",   32'(bus.dmem_be), 32'hF);
            end else begin
                exec_result = 32'h202;
                bus_resp(1'b1, 32'h80011234);
                #1;
                check("lh_done", 32'(mem_stall), 32'h0);
            end
        end
        step();
        check("lh_data", load_data_out, 32'hFFFF8001);
        check("lh_rdwe", 32'(rd_write_enable_out), 32'h1);
        check("lh_rd",   32'(rd_write_addr_out), 32'd7);
        check("lh_alu",  alu_result_out, 32'h202);

        // SH / SB lane replication
        drive_op(RES_ALU, 1'b1, MW_H, 32'h102, 32'h0000ABCD, 1'b0, 5'd0);
        #1;
        check("sh_be",    32'(bus.dmem_be), 32'hC);
        check("sh_wdata", bus.dmem_wdata, 32'hABCDABCD);
        step();
        drive_op(RES_ALU, 1'b1, MW_B, 32'h101, 32'h00000012, 1'b0, 5'd0);
        #1;
        check("sb_be",    32'(bus.dmem_be), 32'h2);
        check("sb_wdata", bus.dmem_wdata, 32'h12121212);
        check("sb_addr",  bus.dmem_addr, 32'h100);
        step();

        // flush while waiting: transfer completes, result dropped
        drive_op(RES_MEM, 1'b0, MW_W, 32'h300, 32'h0, 1'b1, 5'd9);
        bus_resp(1'b0, 32'h0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus_resp(1'b1, 32'h11111111);
        #1;
        check("fl_req",  32'(bus.dmem_req), 32'h1);
        step();
        check("fl_rdwe", 32'(rd_write_enable_out), 32'h0);
        check("fl_ld",   load_data_out, 32'h0);
        check("fl_st",   32'(fsm_state), 32'(ST_IDLE));

        // reset during WAIT, then a clean LW
        drive_op(RES_MEM, 1'b0, MW_W, 32'h400, 32'h0, 1'b1, 5'd3);
        bus_resp(1'b0, 32'h0);
        step();
        check("rw_state", 32'(fsm_state), 32'(ST_WAIT));
        reset = 1'b0;
        #1;
        check("rw_req",   32'(bus.dmem_req), 32'h0);
        check("rw_st",    32'(fsm_state), 32'(ST_IDLE));
        check("rw_stall", 32'(mem_stall), 32'h0);
        check("rw_fwd",   mem_forward, 32'h0);
        step();
        reset = 1'b1;
        drive_op(RES_MEM, 1'b0, MW_W, 32'h404, 32'h0, 1'b1, 5'd3);
        bus_resp(1'b1, 32'hCAFEF00D);
        #1;
        check("rl_req",  32'(bus.dmem_req), 32'h1);
        check("rl_addr", bus.dmem_addr, 32'h404);
        step();
        check("rl_data", load_data_out, 32'hCAFEF00D);
        check("rl_rdwe", 32'(rd_write_enable_out), 32'h1);

        // stall_in holds MEM/WB; PC+4 path passes through afterwards
        drive_op(RES_PC4, 1'b0, MW_W, 32'h55, 32'h0, 1'b1, 5'd4);
        stall_in = 1'b1;
        step();
        check("hold_alu", alu_result_out, 32'h404);
        check("hold_ld",  load_data_out, 32'hCAFEF00D);
        check("fwd",      mem_forward, 32'h55);
        stall_in = 1'b0;
        step();
        check("pc4_src", 32'(res_src_out), 32'(RES_PC4));
        check("pc4_pc",  next_pc_out, 32'h59);
        check("pc4_rd",  32'(rd_write_addr_out), 32'd4);
        check("pc4_alu", alu_result_out, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
